// File: rtl/pattern_seq_pkg.sv
// Shared types and default sizing for the pattern sequencer.
package pattern_seq_pkg;

  localparam int unsigned DEF_BUFFER_SIZE  = 32;
  localparam int unsigned DEF_BUFFER_WIDTH = 6;
  localparam int unsigned DEF_NUM_BUFFERS  = 8;
  localparam int unsigned BUF_IDX_W        = 3;
  localparam int unsigned LOOP_CNT_W       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    SWAP  = 2'd2,
    WRITE = 2'd3
  } seq_state_t;

  // Saturating increment for the wrap counter
  function automatic logic [LOOP_CNT_W-1:0] sat_inc(input logic [LOOP_CNT_W-1:0] v);
    return (v == '1) ? v : v + LOOP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/field_write_arbiter.sv
// Write-grant decision and target-field decode for the pattern sequencer.
module field_write_arbiter
  import pattern_seq_pkg::*;
#(
  parameter int unsigned BUFFER_SIZE = DEF_BUFFER_SIZE
) (
  input  logic                           wr_req,
  input  logic [$clog2(BUFFER_SIZE)-1:0] wr_idx,
  input  seq_state_t                     state,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           step,
  input  logic                           stalled,
  output logic                           grant_c,
  output logic                           field_write_c,
  output logic [BUFFER_SIZE-1:0]         fieldwp_c
);

  // Grant only on a quiet IDLE/RUN cycle: stop, start and any step (live or stalled) win
  always_comb begin
    grant_c = 1'b0;
    if (wr_req && !stop && !step) begin
      grant_c = ((state == IDLE) && !start) || ((state == RUN) && !stalled);
    end
  end

  // Decode the target field; an out-of-range index decodes to no field at all
  always_comb begin
    field_write_c = (32'(wr_idx) < BUFFER_SIZE);
    fieldwp_c     = '0;
    for (int i = 0; i < BUFFER_SIZE; i++) begin
      fieldwp_c[i] = field_write_c && (32'(wr_idx) == 32'(i));
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// Pattern buffer playback sequencer: one-hot field pointer, buffer swap at wrap,
// single-cycle field writes. Optional wrap counter enabled by SEQ_LOOP_COUNT_EN.
module pattern_sequencer
  import pattern_seq_pkg::*;
#(
  parameter int unsigned BUFFER_SIZE  = DEF_BUFFER_SIZE,
  parameter int unsigned BUFFER_WIDTH = DEF_BUFFER_WIDTH,
  parameter int unsigned NUM_BUFFERS  = DEF_NUM_BUFFERS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           step,
  input  logic                           next_buf_valid,
  input  logic [BUF_IDX_W-1:0]           next_buf,
  input  logic                           wr_req,
  input  logic [BUF_IDX_W-1:0]           wr_buf,
  input  logic [$clog2(BUFFER_SIZE)-1:0] wr_idx,
  input  logic [BUFFER_WIDTH-1:0]        wr_data,
  output logic                           wr_ack,
  output logic [BUF_IDX_W-1:0]           bufp,
  output logic [BUF_IDX_W-1:0]           buffer_select,
  output logic [BUFFER_SIZE-1:0]         fieldp,
  output logic [BUFFER_SIZE-1:0]         fieldwp,
  output logic [BUFFER_WIDTH-1:0]        field_in,
  output logic                           field_write,
  output logic                           running,
  output logic                           wrap,
  output logic [LOOP_CNT_W-1:0]          loop_count
);

  seq_state_t             state;
  seq_state_t             prior;
  logic                   pend_valid;
  logic [BUF_IDX_W-1:0]   pend_buf;
  logic                   stalled;
  logic                   step_now_c;
  logic                   nb_ok_c;
  logic                   grant_c;
  logic                   fw_c;
  logic [BUFFER_SIZE-1:0] fwp_c;

  assign step_now_c = step | stalled;
  assign nb_ok_c    = (32'(next_buf) < NUM_BUFFERS);

  field_write_arbiter #(
    .BUFFER_SIZE (BUFFER_SIZE)
  ) u_arb (
    .wr_req        (wr_req),
    .wr_idx        (wr_idx),
    .state         (state),
    .start         (start),
    .stop          (stop),
    .step          (step),
    .stalled       (stalled),
    .grant_c       (grant_c),
    .field_write_c (fw_c),
    .fieldwp_c     (fwp_c)
  );

  // Playback FSM: pointer rotation, wrap/swap, write cycle, stop handling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      prior         <= IDLE;
      bufp          <= '0;
      buffer_select <= '0;
      fieldp        <= BUFFER_SIZE'(1);
      fieldwp       <= '0;
      field_in      <= '0;
      field_write   <= 1'b0;
      wr_ack        <= 1'b0;
      wrap          <= 1'b0;
      running       <= 1'b0;
      pend_valid    <= 1'b0;
      pend_buf      <= '0;
      stalled       <= 1'b0;
    end else begin
      wrap        <= 1'b0;
      wr_ack      <= 1'b0;
      field_write <= 1'b0;
      fieldwp     <= '0;

      case (state)
        IDLE: begin
          if (!stop && start) begin
            state   <= RUN;
            running <= 1'b1;
            fieldp  <= BUFFER_SIZE'(1);
          end
        end
        RUN: begin
          if (stop) begin
            state   <= IDLE;
            running <= 1'b0;
            stalled <= 1'b0;
          end else if (step_now_c) begin
            // a live step arriving while a stalled one drains becomes the new stalled step
            fieldp  <= {fieldp[BUFFER_SIZE-2:0], fieldp[BUFFER_SIZE-1]};
            stalled <= stalled & step;
            if (fieldp[BUFFER_SIZE-1]) begin
              wrap <= 1'b1;
              if (pend_valid) state <= SWAP;
            end
          end
        end
        SWAP: begin
          if (stop) begin
            state   <= IDLE;
            running <= 1'b0;
            stalled <= 1'b0;
          end else begin
            bufp       <= pend_buf;
            pend_valid <= 1'b0;
            state      <= RUN;
            if (step) stalled <= 1'b1;
          end
        end
        WRITE: begin
          if (stop) begin
            state   <= IDLE;
            running <= 1'b0;
            stalled <= 1'b0;
          end else begin
            state <= prior;
            if (step && (prior == RUN)) stalled <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // grant_c already excludes stop, start and step cycles, so nothing above conflicts
      if (grant_c) begin
        state         <= WRITE;
        prior         <= state;
        wr_ack        <= 1'b1;
        field_write   <= fw_c;
        fieldwp       <= fwp_c;
        buffer_select <= wr_buf;
        field_in      <= wr_data;
      end

      // a new request overrides both an older one and the clear done in SWAP
      if (next_buf_valid && nb_ok_c) begin
        pend_valid <= 1'b1;
        pend_buf   <= next_buf;
      end
    end
  end

`ifdef SEQ_LOOP_COUNT_EN
  logic wrap_ev_c;
  logic start_ev_c;

  assign wrap_ev_c  = (state == RUN) && !stop && step_now_c && fieldp[BUFFER_SIZE-1];
  assign start_ev_c = (state == IDLE) && start && !stop;

  // Wrap counter: cleared by an accepted start, saturates at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             loop_count <= '0;
    else if (start_ev_c) loop_count <= '0;
    else if (wrap_ev_c)  loop_count <= sat_inc(loop_count);
  end
`else
  assign loop_count = '0;
`endif

endmodule

// File: tb/tb_pattern_sequencer.sv
// Self-checking bench for pattern_sequencer with a position-based reference model.
module tb_pattern_sequencer;

  localparam int BS = 32;
`ifdef SEQ_LOOP_COUNT_EN
  localparam bit LC_EN = 1'b1;
`else
  localparam bit LC_EN = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_SWAP  = 2;
  localparam int M_WRITE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, step, next_buf_valid, wr_req;
  logic [2:0]  next_buf, wr_buf;
  logic [4:0]  wr_idx;
  logic [5:0]  wr_idx_w;
  logic [5:0]  wr_data;

  logic        wr_ack, field_write, running, wrap;
  logic [2:0]  bufp, buffer_select;
  logic [31:0] fieldp, fieldwp;
  logic [5:0]  field_in;
  logic [7:0]  loop_count;

  logic        wr_ack_w, field_write_w, running_w, wrap_w;
  logic [2:0]  bufp_w, buffer_select_w;
  logic [39:0] fieldp_w, fieldwp_w;
  logic [5:0]  field_in_w;
  logic [7:0]  loop_count_w;

  int total = 0;
  int bad   = 0;

  // reference model state
  int          m_mode, m_prior, m_pos, m_buf, m_pend_b, m_bsel, m_fin, m_lc;
  bit          m_pend_v, m_stall, m_wrap, m_ack, m_fw;
  logic [31:0] m_fwp;

  always #5 clk = ~clk;

  pattern_sequencer u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step),
    .next_buf_valid(next_buf_valid), .next_buf(next_buf),
    .wr_req(wr_req), .wr_buf(wr_buf), .wr_idx(wr_idx), .wr_data(wr_data),
    .wr_ack(wr_ack), .bufp(bufp), .buffer_select(buffer_select),
    .fieldp(fieldp), .fieldwp(fieldwp), .field_in(field_in),
    .field_write(field_write), .running(running), .wrap(wrap),
    .loop_count(loop_count)
  );

  // second instance with 40 fields so that index 40 is representable and out of range
  pattern_sequencer #(.BUFFER_SIZE(40)) u_wide (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step),
    .next_buf_valid(next_buf_valid), .next_buf(next_buf),
    .wr_req(wr_req), .wr_buf(wr_buf), .wr_idx(wr_idx_w), .wr_data(wr_data),
    .wr_ack(wr_ack_w), .bufp(bufp_w), .buffer_select(buffer_select_w),
    .fieldp(fieldp_w), .fieldwp(fieldwp_w), .field_in(field_in_w),
    .field_write(field_write_w), .running(running_w), .wrap(wrap_w),
    .loop_count(loop_count_w)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_mode = M_IDLE; m_prior = M_IDLE; m_pos = 0; m_buf = 0; m_pend_b = 0;
    m_bsel = 0; m_fin = 0; m_lc = 0; m_pend_v = 0; m_stall = 0;
    m_wrap = 0; m_ack = 0; m_fw = 0; m_fwp = '0;
  endtask

  task automatic m_grant(input int prior);
    m_mode = M_WRITE; m_prior = prior; m_ack = 1;
    if (int'(wr_idx) < BS) begin
      m_fw  = 1;
      m_fwp = 32'(1) << wr_idx;
    end
    m_bsel = int'(wr_buf);
    m_fin  = int'(wr_data);
  endtask

  // Apply one clock edge of the specified behaviour to the model using current inputs
  task automatic model_edge();
    bit eff;
    m_wrap = 0; m_ack = 0; m_fw = 0; m_fwp = '0;
    eff = step || m_stall;
    if (m_mode == M_IDLE) begin
      if (stop) begin
      end else if (start) begin
        m_mode = M_RUN; m_pos = 0; m_lc = 0;
      end else if (wr_req && !step) m_grant(M_IDLE);
    end else if (m_mode == M_RUN) begin
      if (stop) begin
        m_mode = M_IDLE; m_stall = 0;
      end else if (eff) begin
        m_stall = m_stall && step;
        m_pos   = (m_pos + 1) % BS;
        if (m_pos == 0) begin
          m_wrap = 1;
          if (m_lc < 255) m_lc++;
          if (m_pend_v) m_mode = M_SWAP;
        end
      end else if (wr_req) m_grant(M_RUN);
    end else if (m_mode == M_SWAP) begin
      if (stop) begin
        m_mode = M_IDLE; m_stall = 0;
      end else begin
        m_buf = m_pend_b; m_pend_v = 0; m_mode = M_RUN;
        if (step) m_stall = 1;
      end
    end else begin
      if (stop) begin
        m_mode = M_IDLE; m_stall = 0;
      end else begin
        if (step && m_prior == M_RUN) m_stall = 1;
        m_mode = m_prior;
      end
    end
    if (next_buf_valid) begin
      m_pend_v = 1; m_pend_b = int'(next_buf);
    end
  endtask

  task automatic check_all();
    bit exp_run;
    exp_run = (m_mode == M_RUN) || (m_mode == M_SWAP) || (m_mode == M_WRITE && m_prior == M_RUN);
    chk("fieldp",        64'(fieldp),        64'(1) << m_pos);
    chk("bufp",          64'(bufp),          64'(m_buf));
    chk("wrap",          64'(wrap),          64'(m_wrap));
    chk("running",       64'(running),       64'(exp_run));
    chk("wr_ack",        64'(wr_ack),        64'(m_ack));
    chk("field_write",   64'(field_write),   64'(m_fw));
    chk("fieldwp",       64'(fieldwp),       64'(m_fwp));
    chk("buffer_select", 64'(buffer_select), 64'(m_bsel));
    chk("field_in",      64'(field_in),      64'(m_fin));
    chk("loop_count",    64'(loop_count),    LC_EN ? 64'(m_lc) : 64'(0));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_fieldp"},   64'(fieldp),        64'(1));
    chk({tag, "_bufp"},     64'(bufp),          64'(0));
    chk({tag, "_bsel"},     64'(buffer_select), 64'(0));
    chk({tag, "_fieldwp"},  64'(fieldwp),       64'(0));
    chk({tag, "_field_in"}, 64'(field_in),      64'(0));
    chk({tag, "_fwrite"},   64'(field_write),   64'(0));
    chk({tag, "_wr_ack"},   64'(wr_ack),        64'(0));
    chk({tag, "_wrap"},     64'(wrap),          64'(0));
    chk({tag, "_running"},  64'(running),       64'(0));
    chk({tag, "_lc"},       64'(loop_count),    64'(0));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; start = 0; stop = 0; step = 0; next_buf_valid = 0; next_buf = '0;
    wr_req = 0; wr_buf = '0; wr_idx = '0; wr_idx_w = '0; wr_data = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    chk("wide_reset_fieldp", 64'(fieldp_w), 64'(1));
    chk("wide_reset_misc", 64'({bufp_w, buffer_select_w, field_in_w, wrap_w, running_w, loop_count_w}), 64'(0));
    rst = 1'b0;
    tick();

    // Field write from IDLE; wide instance sees an out-of-range index
    wr_req = 1; wr_buf = 3'd3; wr_idx = 5'd7; wr_idx_w = 6'd40; wr_data = 6'h2A;
    tick();
    chk("wr_ack",      64'(wr_ack),        64'(1));
    chk("wr_fwrite",   64'(field_write),   64'(1));
    chk("wr_fieldwp",  64'(fieldwp),       64'h80);
    chk("wr_bsel",     64'(buffer_select), 64'(3));
    chk("wr_data",     64'(field_in),      64'h2A);
    chk("oor_ack",     64'(wr_ack_w),      64'(1));
    chk("oor_fwrite",  64'(field_write_w), 64'(0));
    chk("oor_fieldwp", 64'(fieldwp_w),     64'(0));
    wr_req = 0; wr_idx_w = '0;
    tick();
    chk("wr_ack_drop", 64'(wr_ack), 64'(0));

    // Start, then a full lap of steps
    start = 1;
    tick();
    start = 0;
    chk("start_running", 64'(running), 64'(1));
    step = 1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk("walk_fieldp", 64'(fieldp), 64'(1) << (k % 32));
      chk("walk_wrap",   64'(wrap),   64'(k == 32));
    end

    // Pending buffer swap requested mid-pattern
    for (int k = 0; k < 10; k++) begin
      next_buf_valid = (k == 4); next_buf = 3'd5;
      tick();
    end
    next_buf_valid = 0;
    for (int k = 0; k < 22; k++) begin
      tick();
      chk("swap_bufp_before", 64'(bufp), 64'(0));
    end
    chk("swap_wrap", 64'(wrap), 64'(1));
    tick();
    chk("swap_bufp",   64'(bufp),   64'(5));
    chk("swap_fieldp", 64'(fieldp), 64'(1));
    tick();
    chk("swap_after", 64'(fieldp), 64'(2));
    step = 0;
    tick();
    chk("stalled_applied", 64'(fieldp), 64'(4));
    tick();
    chk("stalled_once", 64'(fieldp), 64'(4));

    // Write request colliding with a step: step first, write next cycle
    step = 1; wr_req = 1; wr_buf = 3'd6; wr_idx = 5'd20; wr_data = 6'h15;
    tick();
    chk("coll_step",  64'(fieldp), 64'(8));
    chk("coll_noack", 64'(wr_ack), 64'(0));
    step = 0;
    tick();
    chk("coll_ack",     64'(wr_ack),  64'(1));
    chk("coll_fieldwp", 64'(fieldwp), 64'(1) << 20);
    wr_req = 0;
    tick();

    // Step arriving during WRITE is stalled then applied
    wr_req = 1; wr_idx = 5'd0;
    tick();
    wr_req = 0; step = 1;
    tick();
    chk("wstall_hold", 64'(fieldp), 64'(8));
    step = 0;
    tick();
    chk("wstall_apply", 64'(fieldp), 64'(16));

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      start = ($urandom_range(0, 99) < 8);
      stop  = ($urandom_range(0, 99) < 3);
      step  = 1'($urandom_range(0, 1));
      next_buf_valid = ($urandom_range(0, 99) < 10);
      next_buf = 3'($urandom_range(0, 7));
      if (!wr_req && $urandom_range(0, 99) < 20) begin
        wr_req  = 1;
        wr_buf  = 3'($urandom_range(0, 7));
        wr_idx  = 5'($urandom_range(0, 31));
        wr_data = 6'($urandom_range(0, 63));
        wr_idx_w = {1'b0, wr_idx};
      end
      tick();
      if (m_ack) wr_req = 0;
    end
    start = 0; step = 0; next_buf_valid = 0; wr_req = 0;

    // Long run for the wrap counter
    stop = 1;
    tick();
    stop = 0; start = 1;
    tick();
    start = 0; step = 1;
    for (int k = 0; k < 300 * 32 + 40; k++) tick();
    chk("loop_count_300", 64'(loop_count), LC_EN ? 64'(255) : 64'(0));
    step = 0;

    // Reset asserted in the middle of a WRITE cycle
    stop = 1;
    tick();
    stop = 0; wr_req = 1; wr_idx = 5'd3;
    tick();
    chk("rstw_ack_seen", 64'(wr_ack), 64'(1));
    rst = 1;
    #2;
    check_reset("rst_in_write");
    m_reset();
    @(posedge clk);
    #1;
    rst = 0; wr_req = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
